seven_segment_reader: RTL and testbench

SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

---
 rtl/seven_segment_reader_pkg.sv | 41 ++++
 rtl/seven_segment_reader_seg7_to_bcd.sv | 34 +++
 rtl/seven_segment_reader.sv | 212 +++++++++++++++++++++
 tb/tb_seven_segment_reader.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/seven_segment_reader_pkg.sv
// Shared definitions for the seven-segment display reader.
//   - Segment patterns for digits 0..9 (bit6=a .. bit0=g, active-high)
//   - Code reported for an undecodable pattern
//   - FSM state type
//   - Helper that writes one BCD nibble into a 16-bit frame word
package seven_segment_reader_pkg;

    localparam logic [6:0] SegDigit0 = 7'h7E;
    localparam logic [6:0] SegDigit1 = 7'h30;
    localparam logic [6:0] SegDigit2 = 7'h6D;
    localparam logic [6:0] SegDigit3 = 7'h79;
    localparam logic [6:0] SegDigit4 = 7'h33;
    localparam logic [6:0] SegDigit5 = 7'h5B;
    localparam logic [6:0] SegDigit6 = 7'h5F;
    localparam logic [6:0] SegDigit7 = 7'h70;
    localparam logic [6:0] SegDigit8 = 7'h7F;
    localparam logic [6:0] SegDigit9 = 7'h7B;

    localparam logic [3:0] BcdInvalid = 4'hF;

    typedef enum logic {
        StSync = 1'b0,
        StAcq  = 1'b1
    } state_e;

    // Replace nibble 'idx' of 'word' with 'nib'; nibble 0 is bits [3:0].
    function automatic logic [15:0] set_nibble(input logic [15:0] word,
                                               input logic [1:0]  idx,
                                               input logic [3:0]  nib);
        logic [15:0] res;
        res = word;
        case (idx)
            2'd0:    res[3:0]   = nib;
            2'd1:    res[7:4]   = nib;
            2'd2:    res[11:8]  = nib;
            default: res[15:12] = nib;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seven_segment_reader_seg7_to_bcd.sv
// Combinational seven-segment pattern decoder.
//   seg_i     : segment pattern, bit6=a .. bit0=g, active-high
//   bcd_o     : decoded digit 0..9, or 4'hF when the pattern is not a digit
//   invalid_o : high when the pattern is not one of the ten digit patterns
module seg7_to_bcd
    import seven_segment_reader_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] bcd_o,
    output logic       invalid_o
);

    always_comb begin
        bcd_o     = BcdInvalid;
        invalid_o = 1'b0;
        case (seg_i)
            SegDigit0: bcd_o = 4'd0;
            SegDigit1: bcd_o = 4'd1;
            SegDigit2: bcd_o = 4'd2;
            SegDigit3: bcd_o = 4'd3;
            SegDigit4: bcd_o = 4'd4;
            SegDigit5: bcd_o = 4'd5;
            SegDigit6: bcd_o = 4'd6;
            SegDigit7: bcd_o = 4'd7;
            SegDigit8: bcd_o = 4'd8;
            SegDigit9: bcd_o = 4'd9;
            default: begin
                bcd_o     = BcdInvalid;
                invalid_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seven_segment_reader.sv
// Reads a multiplexed four-digit seven-segment display and emits whole frames.
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   Segment    : segment lines (bit6=a .. bit0=g), asynchronous to clk
//   Digit_Sel  : one-hot digit strobes, bit0 = least significant digit
//   BCD_Out    : captured frame, [3:0] = digit0 .. [15:12] = digit3
//   Out_Valid  : BCD_Out / Seg_Err hold a frame (valid/ready handshake)
//   Out_Ready  : consumer accepts the held frame
//   Seg_Err    : held frame contains at least one undecodable digit
//   Overrun    : sticky, a completed frame was dropped while one was held
module seven_segment_reader
    import seven_segment_reader_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  Segment,
    input  logic [3:0]  Digit_Sel,
    output logic [15:0] BCD_Out,
    output logic        Out_Valid,
    input  logic        Out_Ready,
    output logic        Seg_Err,
    output logic        Overrun
);

    localparam logic [7:0] StableCnt = 8'(STABLE_CYCLES);

    // Two-flop synchronizers
    logic [6:0] seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
    logic [3:0] sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;

    // Stability tracking on the synchronized sample
    logic [10:0] prev_q, prev_d;
    logic [7:0]  cnt_q, cnt_d;

    // Frame assembly FSM
    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] frame_q, frame_d;
    logic        err_acc_q, err_acc_d;

    // Output holding registers
    logic [15:0] bcd_q, bcd_d;
    logic        valid_q, valid_d;
    logic        seg_err_q, seg_err_d;
    logic        overrun_q, overrun_d;

    logic [10:0] sample;
    logic        stable_hit;
    logic        sel_onehot;
    logic        accept;
    logic        bad_sel;
    logic [1:0]  sel_idx;
    logic [3:0]  dec_bcd;
    logic        dec_invalid;
    logic        complete;
    logic [15:0] done_frame;
    logic        done_err;

    seg7_to_bcd u_decode (
        .seg_i     (seg_s2_q),
        .bcd_o     (dec_bcd),
        .invalid_o (dec_invalid)
    );

    always_comb begin
        seg_s1_d = Segment;
        seg_s2_d = seg_s1_q;
        sel_s1_d = Digit_Sel;
        sel_s2_d = sel_s1_q;
    end

    assign sample = {sel_s2_q, seg_s2_q};

    // Counter saturates so a long dwell crosses StableCnt exactly once.
    always_comb begin
        prev_d = sample;
        if (sample == prev_q) begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end else begin
            cnt_d = 8'd1;
        end
    end

    assign stable_hit = (cnt_d == StableCnt) && (cnt_q != StableCnt);
    assign sel_onehot = $onehot(sel_s2_q);
    assign accept     = stable_hit && sel_onehot;
    assign bad_sel    = stable_hit && !sel_onehot && (sel_s2_q != 4'b0000);

    always_comb begin
        sel_idx = 2'd0;
        unique case (sel_s2_q)
            4'b0001: sel_idx = 2'd0;
            4'b0010: sel_idx = 2'd1;
            4'b0100: sel_idx = 2'd2;
            4'b1000: sel_idx = 2'd3;
            default: sel_idx = 2'd0;
        endcase
    end

    // Frame assembly
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        frame_d    = frame_q;
        err_acc_d  = err_acc_q;
        complete   = 1'b0;
        done_frame = set_nibble(frame_q, 2'd3, dec_bcd);
        done_err   = err_acc_q | dec_invalid;

        unique case (state_q)
            StSync: begin
                if (accept && sel_idx == 2'd0) begin
                    frame_d   = set_nibble(16'h0000, 2'd0, dec_bcd);
                    err_acc_d = dec_invalid;
                    idx_d     = 2'd1;
                    state_d   = StAcq;
                end
            end
            StAcq: begin
                if (accept) begin
                    if (sel_idx == idx_q) begin
                        if (idx_q == 2'd3) begin
                            complete = 1'b1;
                            idx_d    = 2'd0;
                            state_d  = StSync;
                        end else begin
                            frame_d   = set_nibble(frame_q, idx_q, dec_bcd);
                            err_acc_d = err_acc_q | dec_invalid;
                            idx_d     = idx_q + 2'd1;
                        end
                    end else if (sel_idx == 2'd0) begin
                        // Display restarted its scan: begin a fresh frame.
                        frame_d   = set_nibble(16'h0000, 2'd0, dec_bcd);
                        err_acc_d = dec_invalid;
                        idx_d     = 2'd1;
                    end else begin
                        idx_d   = 2'd0;
                        state_d = StSync;
                    end
                end else if (bad_sel) begin
                    idx_d   = 2'd0;
                    state_d = StSync;
                end
            end
            default: begin
                idx_d   = 2'd0;
                state_d = StSync;
            end
        endcase
    end

    // Output handshake: a held frame is never overwritten until consumed.
    always_comb begin
        bcd_d     = bcd_q;
        valid_d   = valid_q;
        seg_err_d = seg_err_q;
        overrun_d = overrun_q;
        if (complete) begin
            if (!valid_q || Out_Ready) begin
                bcd_d     = done_frame;
                seg_err_d = done_err;
                valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && Out_Ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_s1_q  <= '0;
            seg_s2_q  <= '0;
            sel_s1_q  <= '0;
            sel_s2_q  <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            state_q   <= StSync;
            idx_q     <= '0;
            frame_q   <= '0;
            err_acc_q <= 1'b0;
            bcd_q     <= '0;
            valid_q   <= 1'b0;
            seg_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            seg_s1_q  <= seg_s1_d;
            seg_s2_q  <= seg_s2_d;
            sel_s1_q  <= sel_s1_d;
            sel_s2_q  <= sel_s2_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            err_acc_q <= err_acc_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
            seg_err_q <= seg_err_d;
            overrun_q <= overrun_d;
        end
    end

    assign BCD_Out   = bcd_q;
    assign Out_Valid = valid_q;
    assign Seg_Err   = seg_err_q;
    assign Overrun   = overrun_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader with STABLE_CYCLES = 4.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_seven_segment_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  Segment;
    logic [3:0]  Digit_Sel;
    logic [15:0] BCD_Out;
    logic        Out_Valid;
    logic        Out_Ready;
    logic        Seg_Err;
    logic        Overrun;

    int total = 0;
    int bad   = 0;
    int vcnt  = 0;
    int vbase = 0;

    seven_segment_reader #(
        .STABLE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Segment   (Segment),
        .Digit_Sel (Digit_Sel),
        .BCD_Out   (BCD_Out),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Seg_Err   (Seg_Err),
        .Overrun   (Overrun)
    );

    always #5 clk = ~clk;

    // Counts clock cycles during which Out_Valid was high.
    always @(posedge clk) begin
        if (Out_Valid === 1'b1) vcnt <= vcnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input int n);
        Digit_Sel = sel;
        Segment   = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        drive(4'b0001, s0, 6);
        drive(4'b0010, s1, 6);
        drive(4'b0100, s2, 6);
        drive(4'b1000, s3, 6);
    endtask

    initial begin
        rst_n     = 1'b0;
        Segment   = 7'h00;
        Digit_Sel = 4'b0000;
        Out_Ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(Out_Valid), 32'h0);
        check("rst_bcd", 32'(BCD_Out), 32'h0);
        check("rst_err", 32'(Seg_Err), 32'h0);
        check("rst_overrun", 32'(Overrun), 32'h0);
        rst_n = 1'b1;
        drive(4'b0000, 7'h00, 2);

        // Clean scan 3210, one-cycle latency and single valid pulse
        vbase = vcnt;
        drive(4'b0001, 7'h7E, 6);
        drive(4'b0010, 7'h30, 6);
        drive(4'b0100, 7'h6D, 6);
        drive(4'b1000, 7'h79, 5);
        check("lat_before", 32'(Out_Valid), 32'h0);
        drive(4'b1000, 7'h79, 1);
        check("lat_valid", 32'(Out_Valid), 32'h1);
        check("scan_bcd", 32'(BCD_Out), 32'h3210);
        check("scan_err", 32'(Seg_Err), 32'h0);
        drive(4'b0000, 7'h00, 1);
        check("scan_consumed", 32'(Out_Valid), 32'h0);
        check("scan_pulses", 32'(vcnt - vbase), 32'h1);

        // Short dwell on digit2: frame must be discarded
        vbase = vcnt;
        drive(4'b0001, 7'h7E, 6);
        drive(4'b0010, 7'h30, 6);
        drive(4'b0100, 7'h7F, 3);
        drive(4'b1000, 7'h79, 6);
        drive(4'b0000, 7'h00, 2);
        check("short_valid", 32'(Out_Valid), 32'h0);
        check("short_pulses", 32'(vcnt - vbase), 32'h0);
        check("short_bcd_kept", 32'(BCD_Out), 32'h3210);

        // Undecodable digit1
        frame(7'h7E, 7'h00, 7'h6D, 7'h79);
        check("err_valid", 32'(Out_Valid), 32'h1);
        check("err_bcd", 32'(BCD_Out), 32'h32F0);
        check("err_flag", 32'(Seg_Err), 32'h1);
        drive(4'b0000, 7'h00, 1);

        // Back-pressure and overrun
        Out_Ready = 1'b0;
        frame(7'h33, 7'h79, 7'h6D, 7'h30);
        check("bp_valid1", 32'(Out_Valid), 32'h1);
        check("bp_bcd1", 32'(BCD_Out), 32'h1234);
        check("bp_err1", 32'(Seg_Err), 32'h0);
        check("bp_no_overrun", 32'(Overrun), 32'h0);
        drive(4'b0000, 7'h00, 1);
        frame(7'h7F, 7'h70, 7'h5F, 7'h5B);
        check("ovr_valid", 32'(Out_Valid), 32'h1);
        check("ovr_bcd_kept", 32'(BCD_Out), 32'h1234);
        check("ovr_flag", 32'(Overrun), 32'h1);
        Out_Ready = 1'b1;
        drive(4'b0000, 7'h00, 1);
        check("ovr_drain", 32'(Out_Valid), 32'h0);
        check("ovr_sticky", 32'(Overrun), 32'h1);

        // Bad Digit_Sel in ACQ aborts; trailing digits alone must not complete
        vbase = vcnt;
        drive(4'b0001, 7'h5F, 6);
        drive(4'b0010, 7'h70, 6);
        drive(4'b0011, 7'h7F, 8);
        drive(4'b0100, 7'h7F, 6);
        drive(4'b1000, 7'h7B, 6);
        drive(4'b0000, 7'h00, 2);
        check("badsel_valid", 32'(Out_Valid), 32'h0);
        check("badsel_pulses", 32'(vcnt - vbase), 32'h0);
        frame(7'h5F, 7'h70, 7'h7F, 7'h7B);
        check("resync_valid", 32'(Out_Valid), 32'h1);
        check("resync_bcd", 32'(BCD_Out), 32'h9876);
        drive(4'b0000, 7'h00, 1);

        // Reset after digit2 acceptance discards the partial frame
        vbase = vcnt;
        drive(4'b0001, 7'h7E, 6);
        drive(4'b0010, 7'h30, 6);
        drive(4'b0100, 7'h6D, 6);
        rst_n = 1'b0;
        drive(4'b0100, 7'h6D, 1);
        rst_n = 1'b1;
        check("mrst_valid", 32'(Out_Valid), 32'h0);
        check("mrst_bcd", 32'(BCD_Out), 32'h0);
        check("mrst_err", 32'(Seg_Err), 32'h0);
        check("mrst_overrun", 32'(Overrun), 32'h0);
        drive(4'b1000, 7'h79, 6);
        drive(4'b0000, 7'h00, 2);
        check("mrst_after_valid", 32'(Out_Valid), 32'h0);
        check("mrst_after_bcd", 32'(BCD_Out), 32'h0);
        check("mrst_pulses", 32'(vcnt - vbase), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
